tile_spawner: RTL
=================

TILE_SPAWNER -- requirements
Module: tile_spawner

Interface
REQ-001 The module SHALL have exactly one clock and one reset: reset is asynchronous and active-low; ports named clk and rst as elsewhere in the codebase.
REQ-002 Port `clk`  input  1  system clock; all state updates on the rising edge.
REQ-003 Port `rst`  input  1  asynchronous active-low reset (rst=0 resets immediately).
REQ-004 Port `start`  input  1  request to place one new tile; sampled only in IDLE.
REQ-005 Port `matrix_in`  input  [11:0] x [3:0][3:0]  post-move board; 0 = empty cell, otherwise the literal tile value.
REQ-006 Port `matrix_out`  output  [11:0] x [3:0][3:0]  working board; feeds the game-state register's matrix_D input.
REQ-007 Port `busy`  output  1  high in SCAN and DONE.
REQ-008 Port `done`  output  1  one-cycle completion pulse.
REQ-009 Port `no_space`  output  1  last request found no empty cell.

Function
REQ-010 Cell index i (0..15) SHALL map to row i[3:2], column i[1:0].
REQ-011 The design SHALL contain a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1.
REQ-012 LFSR seed SHALL be 16'hACE1; it shifts on every clock edge out of reset, independent of FSM state.
REQ-013 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-014 IDLE with start=1 at an edge SHALL:
- latch matrix_in into the working board;
- load ptr with the current LFSR[3:0], before that edge's shift;
- set tile value to 4 if LFSR[7:4]==4'h0, else 2;
- clear the checked-cell counter and clear no_space;
- go to SCAN.
REQ-015 IDLE with start=0 SHALL hold all registers except the LFSR.
REQ-016 SCAN, cell[ptr]==0 SHALL write the tile value into cell[ptr] and go to DONE.
REQ-017 SCAN, cell[ptr]!=0 and checked<15 SHALL increment checked and ptr; ptr wraps 15->0.
REQ-018 SCAN, cell[ptr]!=0 and checked==15 SHALL set no_space=1, leave the board unchanged and go to DONE.
REQ-019 DONE SHALL assert done=1 for exactly that cycle and return to IDLE.
REQ-020 Latency: start sampled in cycle 0 SHALL give done=1 in cycle k+2, where k is the number of occupied cells skipped; full board gives done in cycle 17.
REQ-021 start SHALL be ignored in SCAN and DONE: no relatch, no queuing.
REQ-022 Exactly one cell SHALL change per successful request; all other cells equal matrix_in.
REQ-023 matrix_out SHALL always reflect the working board; it is stable from done until the next accepted start.
REQ-024 no_space SHALL remain valid from done until the next accepted start.

Reset
REQ-025 rst=0 SHALL asynchronously force:
- state IDLE, working board all 12'd0, ptr=0, checked=0;
- busy=0, done=0, no_space=0;
- LFSR=16'hACE1.
REQ-026 Reset asserted mid-SCAN or in DONE SHALL abort without a done pulse.
REQ-027 The first edge after rst returns to 1 SHALL treat the LFSR as seed 16'hACE1.

Verification
REQ-028 Bench SHALL cover: start=1 in first cycle after reset release, matrix_in all 0 -> done in cycle 2, cell[0][1]=2 (ptr=1, LFSR[7:4]=E), all other cells 0, no_space=0.
REQ-029 Bench SHALL cover: matrix_in all 12'd2, start -> busy cycles 1..17, done in cycle 17, no_space=1, matrix_out all 2.
REQ-030 Bench SHALL cover: matrix_in all 12'd8 except cell 9 (row 2, col 1)=0, any LFSR phase -> cell 9 becomes 2 or 4, others remain 8, done within 17 cycles, no_space=0.
REQ-031 Bench SHALL cover: start held high continuously on empty board -> one placement per 3-cycle IDLE/SCAN/DONE round; start pulses during SCAN/DONE have no effect.
REQ-032 Bench SHALL cover: full board of 4s, rst=0 during the 5th SCAN cycle -> immediate matrix_out all 0, busy=0, no done pulse, next start behaves as in REQ-028.
REQ-033 Bench SHALL cover: 10,000 requests on random boards -> placement is always in an originally empty cell and the value is only 2 or 4.

Source files
------------

// File: rtl/tile_spawner.sv
// Places one new 2/4 tile into a pseudo-random empty cell of a 4x4 board.
// The start cell comes from a free-running LFSR; a linear probe with wrap finds the first empty cell.
module tile_spawner (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0][3:0][11:0]  matrix_in,
  output logic [3:0][3:0][11:0]  matrix_out,
  output logic                   busy,
  output logic                   done,
  output logic                   no_space
);

  // state | meaning
  // IDLE  | waiting for start; board and flags held
  // SCAN  | probing cell[ptr]; place tile or advance ptr with wrap
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  state_t                  state_q, state_d;
  logic [3:0][3:0][11:0]   board_q, board_d;
  logic [3:0]              ptr_q, ptr_d;
  logic [3:0]              checked_q, checked_d;
  logic [11:0]             tile_q, tile_d;
  logic                    no_space_q, no_space_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic                    lfsr_fb;
  logic [11:0]             cell_cur;

  // Taps 16,14,13,11 expressed on a right-shifting register (bit 0 is the output end).
  always_comb begin
    lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
  end

  assign cell_cur = board_q[ptr_q[3:2]][ptr_q[1:0]];

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    ptr_d      = ptr_q;
    checked_d  = checked_q;
    tile_d     = tile_q;
    no_space_d = no_space_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          board_d    = matrix_in;
          ptr_d      = lfsr_q[3:0];
          tile_d     = (lfsr_q[7:4] == 4'h0) ? 12'd4 : 12'd2;
          checked_d  = 4'd0;
          no_space_d = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (cell_cur == 12'd0) begin
          board_d[ptr_q[3:2]][ptr_q[1:0]] = tile_q;
          state_d = DONE;
        end else if (checked_q != 4'd15) begin
          checked_d = checked_q + 4'd1;
          ptr_d     = ptr_q + 4'd1;
        end else begin
          no_space_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      board_q    <= '0;
      ptr_q      <= 4'd0;
      checked_q  <= 4'd0;
      tile_q     <= 12'd2;
      no_space_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      ptr_q      <= ptr_d;
      checked_q  <= checked_d;
      tile_q     <= tile_d;
      no_space_q <= no_space_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign matrix_out = board_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign no_space   = no_space_q;

endmodule
